// File: rtl/uc_sequencer_if.sv
// Bus bundle between the uc_sequencer and its environment: run control,
// instruction/data memory handshakes, ALU flags and the sequencer status outputs.
interface uc_sequencer_if #(
  parameter int PC_W = 8
);
  logic            run;
  logic [8:0]      imem_instr;
  logic            imem_ack;
  logic            dmem_ack;
  logic [1:0]      flags;
  logic [PC_W-1:0] pc;
  logic            imem_req;
  logic [8:0]      instr;
  logic            dmem_req;
  logic            exec;
  logic            halted;
  logic            fault;
  logic [2:0]      state;

  modport slave (
    input  run, imem_instr, imem_ack, dmem_ack, flags,
    output pc, imem_req, instr, dmem_req, exec, halted, fault, state
  );

  modport master (
    output run, imem_instr, imem_ack, dmem_ack, flags,
    input  pc, imem_req, instr, dmem_req, exec, halted, fault, state
  );
endinterface

// File: rtl/uc_sequencer.sv
// Fetch/decode/execute sequencer for the 9-bit microprocessor: owns PC and IR,
// handshakes with instruction/data memory, commits with a one-cycle strobe.
module uc_sequencer #(
  parameter int PC_W        = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  uc_sequencer_if.slave bus
);
  localparam int TW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    EXEC   = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  state_t          state_r, next_s;
  logic [TW-1:0]   tmo_r;
  logic            tmo_hit_s;
  logic            jump_taken_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [8:0]      ir_r, ir_s;
  logic            imem_req_r, imem_req_s;
  logic            dmem_req_r, dmem_req_s;
  logic            exec_r, exec_s;
  logic            halted_r, halted_s;
  logic            fault_r, fault_s;

  assign tmo_hit_s = (tmo_r == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Wait-cycle counter: restarts on every state entry, counts only while waiting on memory
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_r <= {TW{1'b0}};
    end else if (next_s != state_r) begin
      tmo_r <= {TW{1'b0}};
    end else if (state_r == FETCH || state_r == MEM) begin
      tmo_r <= tmo_r + TW'(1);
    end else begin
      tmo_r <= {TW{1'b0}};
    end
  end

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE:   next_s = bus.run ? FETCH : IDLE;
      FETCH: begin
        if (bus.imem_ack) begin
          next_s = DECODE;
        end else if (tmo_hit_s) begin
          next_s = FAULT;
        end else begin
          next_s = FETCH;
        end
      end
      DECODE: begin
        if (ir_r[8] == 1'b0) begin
          next_s = MEM;
        end else if (ir_r == 9'h1FF) begin
          next_s = HALT;
        end else begin
          next_s = EXEC;
        end
      end
      MEM: begin
        if (bus.dmem_ack) begin
          next_s = EXEC;
        end else if (tmo_hit_s) begin
          next_s = FAULT;
        end else begin
          next_s = MEM;
        end
      end
      EXEC:   next_s = bus.run ? FETCH : IDLE;
      HALT:   next_s = HALT;
      FAULT:  next_s = FAULT;
      default: next_s = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, PC and IR
  always_comb begin
    jump_taken_s = 1'b0;
    case (ir_r[5:4])
      2'b00:   jump_taken_s = 1'b1;
      2'b01:   jump_taken_s = bus.flags[0];
      2'b10:   jump_taken_s = bus.flags[1];
      2'b11:   jump_taken_s = ~bus.flags[0];
      default: jump_taken_s = 1'b0;
    endcase

    if (state_r == FETCH && bus.imem_ack) begin
      ir_s = bus.imem_instr;
    end else begin
      ir_s = ir_r;
    end

    // Flags are sampled on the EXEC edge; jump targets are zero-extended args[3:0]
    if (state_r == EXEC) begin
      if (ir_r[8:6] == 3'b110 && jump_taken_s) begin
        pc_s = PC_W'(ir_r[3:0]);
      end else begin
        pc_s = pc_r + PC_W'(1);
      end
    end else begin
      pc_s = pc_r;
    end

    imem_req_s = (next_s == FETCH);
    dmem_req_s = (next_s == MEM);
    exec_s     = (next_s == EXEC);
    halted_s   = (next_s == HALT);
    fault_s    = (next_s == FAULT);
  end

  // Output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r       <= {PC_W{1'b0}};
      ir_r       <= 9'h000;
      imem_req_r <= 1'b0;
      dmem_req_r <= 1'b0;
      exec_r     <= 1'b0;
      halted_r   <= 1'b0;
      fault_r    <= 1'b0;
    end else begin
      pc_r       <= pc_s;
      ir_r       <= ir_s;
      imem_req_r <= imem_req_s;
      dmem_req_r <= dmem_req_s;
      exec_r     <= exec_s;
      halted_r   <= halted_s;
      fault_r    <= fault_s;
    end
  end

  assign bus.pc       = pc_r;
  assign bus.instr    = ir_r;
  assign bus.imem_req = imem_req_r;
  assign bus.dmem_req = dmem_req_r;
  assign bus.exec     = exec_r;
  assign bus.halted   = halted_r;
  assign bus.fault    = fault_r;
  assign bus.state    = state_r;
endmodule

// File: tb/tb_uc_sequencer.sv
// Scoreboard bench for uc_sequencer: memory responders push the expected commit of
// each fetched instruction, a monitor pops and compares on every exec strobe.
module tb_uc_sequencer;
  logic clk = 1'b0;
  logic rst;

  uc_sequencer_if #(.PC_W(8)) bus ();
  uc_sequencer #(.PC_W(8), .MEM_TIMEOUT(15)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pc;
    logic [8:0] instr;
    logic [7:0] next_pc;
    int         dcyc;
  } exp_t;

  logic [8:0] imem [256];
  logic [1:0] flg  [256];
  int         idly [256];
  int         ddly [256];
  exp_t       sb[$];
  int         exec_cyc[$];

  int         checks = 0;
  int         fails  = 0;
  logic [7:0] model_pc = 8'd0;
  logic [7:0] exp_next = 8'd0;
  bit         chk_next = 1'b0;
  bit         rand_run = 1'b0;
  bit         garbage  = 1'b0;
  bit         wrap_seen = 1'b0;
  int         dcnt  = 0;
  int         cyc   = 0;
  int         n_exec = 0;
  int         cur_ddly = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Architectural rule for the address after an instruction commits
  function automatic logic [7:0] model_next(input logic [7:0] pc, input logic [8:0] ins,
                                            input logic [1:0] f);
    bit take;
    if (ins[8:6] != 3'b110) return pc + 8'd1;
    case (ins[5:4])
      2'd0:    take = 1'b1;
      2'd1:    take = f[0];
      2'd2:    take = f[1];
      default: take = !f[0];
    endcase
    return take ? {4'd0, ins[3:0]} : pc + 8'd1;
  endfunction

  task automatic fill_default();
    for (int a = 0; a < 256; a++) begin
      imem[a] = 9'h100;
      flg[a]  = 2'b00;
      idly[a] = 0;
      ddly[a] = 0;
    end
  endtask

  task automatic do_reset(input bit run_after);
    @(negedge clk);
    rst = 1'b1;
    sb.delete();
    exec_cyc.delete();
    chk_next = 1'b0;
    dcnt     = 0;
    model_pc = 8'd0;
    repeat (2) @(negedge clk);
    bus.run = run_after;
    rst     = 1'b0;
    cyc     = 0;
  endtask

  task automatic wait_execs(input int target, input int budget, input string name);
    int n = 0;
    while (n_exec < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_exec < target) begin
      checks++;
      fails++;
      $display("FAIL %s: timeout, %0d commits seen, %0d required", name, n_exec, target);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Memory responders: imem/dmem acks with per-address latencies, flags per instruction
  initial begin
    int iw = 0;
    int dw = 0;
    logic [8:0] w;
    forever begin
      @(negedge clk);
      if (rst) begin
        iw = 0;
        dw = 0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b0;
      end else begin
        if (bus.imem_req) begin
          if (idly[model_pc] != 255 && iw >= idly[model_pc]) begin
            check("fetch_pc", bus.pc, model_pc);
            w = imem[bus.pc];
            bus.imem_instr = w;
            bus.imem_ack   = 1'b1;
            bus.flags      = flg[model_pc];
            cur_ddly       = ddly[model_pc];
            if (imem[model_pc] != 9'h1FF) begin
              sb.push_back('{model_pc, imem[model_pc],
                             model_next(model_pc, imem[model_pc], flg[model_pc]),
                             (imem[model_pc][8] == 1'b0) ? ddly[model_pc] + 1 : 0});
              model_pc = model_next(model_pc, imem[model_pc], flg[model_pc]);
            end
            iw = 0;
          end else begin
            bus.imem_ack = 1'b0;
            iw++;
          end
        end else begin
          bus.imem_ack   = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
          bus.imem_instr = 9'($urandom);
          iw = 0;
        end
        if (bus.dmem_req) begin
          if (cur_ddly != 255 && dw >= cur_ddly) begin
            bus.dmem_ack = 1'b1;
            dw = 0;
          end else begin
            bus.dmem_ack = 1'b0;
            dw++;
          end
        end else begin
          bus.dmem_ack = garbage ? 1'($urandom_range(0, 1)) : 1'b0;
          dw = 0;
        end
        if (rand_run) bus.run = ($urandom_range(0, 7) != 0);
      end
    end
  end

  // Monitor: every commit strobe pops one expected instruction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (chk_next) begin
          check("pc_after_exec", bus.pc, exp_next);
          chk_next = 1'b0;
        end
        if (bus.dmem_req) dcnt++;
        if (bus.exec) begin
          n_exec++;
          exec_cyc.push_back(cyc);
          if (sb.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL exec_unexpected: commit at pc %0h with empty scoreboard", bus.pc);
          end else begin
            e = sb.pop_front();
            check("exec_pc", bus.pc, e.pc);
            check("exec_instr", bus.instr, e.instr);
            check("dmem_req_cycles", dcnt, e.dcyc);
            if (e.pc == 8'hFF) wrap_seen = 1'b1;
            exp_next = e.next_pc;
            chk_next = 1'b1;
          end
          dcnt = 0;
        end
      end
    end
  end

  initial begin
    int n;
    int n0;
    logic [8:0] w;
    rst = 1'b1;
    bus.run = 1'b0;
    bus.imem_instr = 9'h000;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    bus.flags = 2'b00;
    fill_default();
    #12;
    check("rst_pc", bus.pc, 8'd0);
    check("rst_instr", bus.instr, 9'd0);
    check("rst_flags_out", {bus.imem_req, bus.dmem_req, bus.exec, bus.halted, bus.fault}, 5'd0);
    check("rst_state", bus.state, 3'd0);

    // Directed program: MOVE, NOP, JUMP always, JZ x2, JNZ, LOAD with wait, HALT
    imem[0]  = 9'h10A;
    imem[1]  = 9'h1C0;
    imem[2]  = 9'h185;
    imem[5]  = 9'h199;
    imem[6]  = 9'h199;
    flg[6]   = 2'b01;
    imem[9]  = 9'h1B0;
    flg[9]   = 2'b01;
    imem[10] = 9'h01C;
    ddly[10] = 2;
    imem[11] = 9'h1FF;
    do_reset(1'b1);
    n = 0;
    while (!bus.halted && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("halt_reached", bus.halted, 1'b1);
    check("exec_count_dir", exec_cyc.size() >= 2 ? 32'd1 : 32'd0, 32'd1);
    check("exec_cycle_1", exec_cyc.size() >= 2 ? exec_cyc[0] : -1, 3);
    check("exec_cycle_2", exec_cyc.size() >= 2 ? exec_cyc[1] : -1, 6);
    check("halt_pc", bus.pc, 8'd11);
    check("halt_state", bus.state, 3'd5);
    n0 = n_exec;
    repeat (6) @(negedge clk);
    check("halt_sticky", bus.halted, 1'b1);
    check("halt_pc_frozen", bus.pc, 8'd11);
    check("halt_instr", bus.instr, 9'h1FF);
    check("halt_no_exec", n_exec, n0);
    check("halt_sb_empty", sb.size(), 0);

    // Random programs with random latencies, stray acks and run toggling
    for (int a = 0; a < 256; a++) begin
      w = 9'($urandom);
      if (w == 9'h1FF) w = 9'h1FE;
      imem[a] = w;
      flg[a]  = 2'($urandom);
      idly[a] = $urandom_range(0, 3);
      ddly[a] = $urandom_range(0, 3);
    end
    do_reset(1'b1);
    garbage  = 1'b1;
    rand_run = 1'b1;
    wait_execs(n_exec + 300, 20000, "random_run");
    rand_run = 1'b0;
    bus.run  = 1'b0;
    garbage  = 1'b0;
    n = 0;
    while (bus.state != 3'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("random_idle", bus.state, 3'd0);
    check("random_sb_empty", sb.size(), 0);

    // PC wrap: a straight run of MOVEs through address 255
    fill_default();
    do_reset(1'b1);
    wait_execs(n_exec + 258, 1200, "wrap_run");
    check("wrap_seen", wrap_seen, 1'b1);

    // Fetch timeout
    fill_default();
    idly[0] = 255;
    do_reset(1'b1);
    n = 0;
    for (int i = 0; i < 40 && !bus.fault; i++) begin
      @(negedge clk);
      if (bus.imem_req) n++;
    end
    check("fetch_tmo_cycles", n, 15);
    check("fault_set", bus.fault, 1'b1);
    check("fault_reqs", {bus.imem_req, bus.dmem_req}, 2'b00);
    check("fault_state", bus.state, 3'd6);
    check("fault_pc", bus.pc, 8'd0);
    garbage = 1'b1;
    repeat (5) @(negedge clk);
    garbage = 1'b0;
    check("fault_sticky", bus.fault, 1'b1);
    check("fault_state_hold", bus.state, 3'd6);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("fault_rst_clear", bus.fault, 1'b0);
    check("fault_rst_pc", bus.pc, 8'd0);

    // Data-memory timeout
    fill_default();
    imem[0] = 9'h01C;
    ddly[0] = 255;
    do_reset(1'b1);
    n = 0;
    for (int i = 0; i < 60 && !bus.fault; i++) begin
      @(negedge clk);
      if (bus.dmem_req) n++;
    end
    check("dmem_tmo_cycles", n, 15);
    check("dmem_fault_state", bus.state, 3'd6);

    // Asynchronous reset in the middle of a LOAD wait
    fill_default();
    imem[1] = 9'h01C;
    ddly[1] = 10;
    do_reset(1'b1);
    n = 0;
    while (!bus.dmem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    check("mem_wait_reached", bus.dmem_req, 1'b1);
    check("mem_wait_pc", bus.pc, 8'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_dmem_req", bus.dmem_req, 1'b0);
    check("async_rst_pc", bus.pc, 8'd0);
    check("async_rst_state", bus.state, 3'd0);
    do_reset(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
